brightness_sequencer: RTL and testbench

BRIGHTNESS_SEQUENCER -- requirements
Module: brightness_sequencer

---
 rtl/brightness_sequencer_pkg.sv | 23 ++
 rtl/brightness_sequencer_watchdog.sv | 29 ++
 rtl/brightness_sequencer.sv | 126 ++++++++++++
 tb/tb_brightness_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_sequencer_pkg.sv
// Shared parameters and types for the row/bit-plane brightness sequencer.
// Optional watchdog: define BRIGHTNESS_SEQ_WATCHDOG_EN.
package params;
  localparam int BRIGHTNESS_LEVELS   = 4;
  localparam int SCAN_ROWS           = 2;
  localparam int SEQ_WATCHDOG_CYCLES = 16;
endpackage

package types;
  localparam int ROW_W =
    (params::SCAN_ROWS > 1) ? $clog2(params::SCAN_ROWS) : 1;

  typedef logic [params::BRIGHTNESS_LEVELS-1:0] brightness_level_t;
  typedef logic [ROW_W-1:0] row_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_OE,
    LATCH,
    WAIT_OVERLAP
  } brightness_seq_state_t;
endpackage

// File: rtl/brightness_sequencer_watchdog.sv
// SHIFT-phase timeout counter; only built with BRIGHTNESS_SEQ_WATCHDOG_EN.
// expired is high during the CYCLES-th enabled cycle after a clear.
`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
module seq_watchdog #(
  parameter int CYCLES = params::SEQ_WATCHDOG_CYCLES
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/brightness_sequencer.sv
// Row/bit-plane sequencer: shift, wait for OE idle, latch, wait overlap.
// Optional SHIFT watchdog: define BRIGHTNESS_SEQ_WATCHDOG_EN.
module brightness_sequencer
  import types::*;
#(
  parameter int BRIGHTNESS_LEVELS = params::BRIGHTNESS_LEVELS,
  parameter int SCAN_ROWS         = params::SCAN_ROWS
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              run,
  input  logic              shift_done,
  input  logic              output_enable,
  input  logic              exceeded_overlap_time,
  output logic              shift_start,
  output brightness_level_t brightness_mask_shift,
  output brightness_level_t brightness_mask_active,
  output row_addr_t         row_address,
  output logic              row_latch,
`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
  output logic              watchdog_error,
`endif
  output logic              frame_done
);
  brightness_seq_state_t state, state_nxt;

  row_addr_t         shift_row;
  brightness_level_t mask_rot;
  logic              wrap;
  logic              row_last;
  logic              shift_go;

`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
  logic wd_expired;
  logic wd_err_q;

  seq_watchdog #(
    .CYCLES (params::SEQ_WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk_in  (clk_in),
    .reset   (reset),
    .clear   (state != SHIFT),
    .enable  (state == SHIFT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wd_err_q <= 1'b0;
    end else if (wd_expired) begin
      wd_err_q <= 1'b1;
    end
  end

  assign watchdog_error = wd_err_q | wd_expired;
  // a timeout is treated exactly like a late shift_done
  assign shift_go = shift_done | wd_expired;
`else
  assign shift_go = shift_done;
`endif

  assign wrap      = brightness_mask_shift[BRIGHTNESS_LEVELS-1];
  assign row_last  = (shift_row == row_addr_t'(SCAN_ROWS - 1));
  assign row_latch = (state == LATCH);
  assign frame_done = row_latch && wrap && row_last;

  always_comb begin
    mask_rot = '0;
    for (int i = 0; i < BRIGHTNESS_LEVELS; i++) begin
      mask_rot[(i + 1) % BRIGHTNESS_LEVELS] = brightness_mask_shift[i];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (shift_go) state_nxt = WAIT_OE;
      end
      WAIT_OE: begin
        if (!output_enable) state_nxt = LATCH;
      end
      LATCH: begin
        state_nxt = WAIT_OVERLAP;
      end
      WAIT_OVERLAP: begin
        // run is only honoured here, so a started row always latches
        if (!exceeded_overlap_time && !row_latch) begin
          state_nxt = run ? SHIFT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_start <= (state_nxt == SHIFT) && (state != SHIFT);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      brightness_mask_shift  <= brightness_level_t'(1);
      brightness_mask_active <= '0;
      row_address            <= '0;
      shift_row              <= '0;
    end else if (state == LATCH) begin
      brightness_mask_active <= brightness_mask_shift;
      row_address            <= shift_row;
      brightness_mask_shift  <= mask_rot;
      if (wrap) begin
        shift_row <= row_last ? '0 : shift_row + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_brightness_sequencer.sv
// Bench for brightness_sequencer: table of rows plus corner sequences.
// Watchdog sequence is included when BRIGHTNESS_SEQ_WATCHDOG_EN is set.
module tb_brightness_sequencer;
  import types::*;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              run;
  logic              shift_done;
  logic              output_enable;
  logic              exceeded_overlap_time;
  logic              shift_start;
  brightness_level_t brightness_mask_shift;
  brightness_level_t brightness_mask_active;
  row_addr_t         row_address;
  logic              row_latch;
  logic              frame_done;
`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
  logic              watchdog_error;
`endif

  brightness_sequencer #(
    .BRIGHTNESS_LEVELS (4),
    .SCAN_ROWS         (2)
  ) dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .run                    (run),
    .shift_done             (shift_done),
    .output_enable          (output_enable),
    .exceeded_overlap_time  (exceeded_overlap_time),
    .shift_start            (shift_start),
    .brightness_mask_shift  (brightness_mask_shift),
    .brightness_mask_active (brightness_mask_active),
    .row_address            (row_address),
    .row_latch              (row_latch),
`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
    .watchdog_error         (watchdog_error),
`endif
    .frame_done             (frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         oe_hold;
    int         exc_hold;
    int         row;
    logic [3:0] mask;
    logic       fd;
  } vec_t;

  vec_t tbl[10];
  vec_t q[$];

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int exp_starts = 0;
  int frames = 0;

  always @(negedge clk_in) begin
    if (shift_start) starts++;
    if (frame_done) frames++;
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ss(string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!shift_start && n < 20);
    check(name, n, 1);
  endtask

  task automatic wait_latch(string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!row_latch && n < 20);
    check(name, n, 1);
  endtask

  task automatic pop_cmp(string name);
    vec_t e;
    if (q.size() == 0) begin
      check({name, "_queue"}, 0, 1);
    end else begin
      e = q.pop_front();
      check({name, "_fd"}, int'(frame_done), int'(e.fd));
      tick();
      check({name, "_row"}, int'(row_address), e.row);
      check({name, "_mask"}, int'(brightness_mask_active), int'(e.mask));
    end
  endtask

  task automatic run_row(input vec_t r, input bit drop_run);
    int early;
    wait_ss("start_latency");
    q.push_back(r);
    exp_starts++;
    if (drop_run) run = 1'b0;
    repeat (3) tick();
    shift_done = 1'b1;
    output_enable = (r.oe_hold > 0);
    tick();
    shift_done = 1'b0;
    early = 0;
    for (int i = 1; i < r.oe_hold; i++) begin
      if (row_latch) early++;
      tick();
    end
    if (row_latch) early++;
    output_enable = 1'b0;
    check("early_latch", early, 0);
    wait_latch("latch_latency");
    exceeded_overlap_time = (r.exc_hold > 0);
    pop_cmp("latch");
    early = 0;
    for (int i = 1; i < r.exc_hold; i++) begin
      tick();
      if (shift_start) early++;
    end
    exceeded_overlap_time = 1'b0;
    check("early_start", early, 0);
  endtask

  initial begin
    int s0;
    tbl[0] = '{0, 0, 0, 4'b0001, 1'b0};
    tbl[1] = '{0, 0, 0, 4'b0010, 1'b0};
    tbl[2] = '{10, 0, 0, 4'b0100, 1'b0};
    tbl[3] = '{0, 0, 0, 4'b1000, 1'b0};
    tbl[4] = '{0, 0, 1, 4'b0001, 1'b0};
    tbl[5] = '{0, 5, 1, 4'b0010, 1'b0};
    tbl[6] = '{0, 0, 1, 4'b0100, 1'b0};
    tbl[7] = '{0, 0, 1, 4'b1000, 1'b1};
    tbl[8] = '{0, 0, 0, 4'b0001, 1'b0};
    tbl[9] = '{3, 2, 0, 4'b0010, 1'b0};

    reset = 1'b1;
    run = 1'b0;
    shift_done = 1'b0;
    output_enable = 1'b0;
    exceeded_overlap_time = 1'b0;
    repeat (2) tick();
    check("rst_shift_start", int'(shift_start), 0);
    check("rst_mask_shift", int'(brightness_mask_shift), 1);
    check("rst_mask_active", int'(brightness_mask_active), 0);
    check("rst_row", int'(row_address), 0);
    check("rst_latch", int'(row_latch), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_no_start", starts, 0);

    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_row(tbl[i], 1'b0);
    end
    check("frame_count", frames, 1);

    run_row('{0, 0, 0, 4'b0100, 1'b0}, 1'b1);
    s0 = starts;
    repeat (20) tick();
    check("idle_after_stop", starts - s0, 0);
    run = 1'b1;
    run_row('{0, 0, 0, 4'b1000, 1'b0}, 1'b0);

    wait_ss("rst_test_start");
    exp_starts++;
    repeat (2) tick();
    shift_done = 1'b1;
    output_enable = 1'b1;
    tick();
    shift_done = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midrst_shift_start", int'(shift_start), 0);
    check("midrst_mask_shift", int'(brightness_mask_shift), 1);
    check("midrst_mask_active", int'(brightness_mask_active), 0);
    check("midrst_row", int'(row_address), 0);
    check("midrst_latch", int'(row_latch), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    output_enable = 1'b0;
    s0 = 0;
    repeat (3) begin
      tick();
      if (row_latch) s0++;
    end
    check("midrst_no_latch", s0, 0);
    reset = 1'b0;
    run_row('{0, 0, 0, 4'b0001, 1'b0}, 1'b0);

`ifdef BRIGHTNESS_SEQ_WATCHDOG_EN
    wait_ss("wd_start");
    q.push_back('{0, 0, 0, 4'b0010, 1'b0});
    exp_starts++;
    check("wd_clear", int'(watchdog_error), 0);
    repeat (14) tick();
    check("wd_not_yet", int'(watchdog_error), 0);
    tick();
    check("wd_fire", int'(watchdog_error), 1);
    tick();
    wait_latch("wd_latch_latency");
    pop_cmp("wd_latch");
    check("wd_sticky", int'(watchdog_error), 1);
`endif

    check("start_pulses", starts, exp_starts);
    check("frame_total", frames, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
